// File: rtl/uart_tx_pkg.sv
// Shared types and register-map constants for the memory-mapped UART transmitter.
package uart_tx_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_e;

  localparam logic [1:0] OFF_TXDATA = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_CTRL   = 2'd2;
  localparam logic [1:0] OFF_RSVD   = 2'd3;

  localparam int unsigned ST_FULL      = 0;
  localparam int unsigned ST_EMPTY     = 1;
  localparam int unsigned ST_BUSY      = 2;
  localparam int unsigned ST_OVF       = 3;
  localparam int unsigned ST_COUNT_LSB = 8;

  localparam int unsigned DIV_W       = 16;
  localparam int unsigned CTRL_IE_BIT = 16;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; pointers carry an extra wrap bit so full and empty are distinguishable.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count   = wr_ptr - rd_ptr;
  assign rdata   = mem[rd_ptr[AW-1:0]];
  assign do_pop  = pop & ~empty;
  // A simultaneous pop frees the slot, so a push into a full FIFO is still accepted.
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      if (do_pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped UART transmitter on the core's data-memory port.
// Optional even-parity bit enabled by defining UART_TX_PARITY_EN.
module uart_tx_mmio
  import uart_tx_pkg::*;
#(
  parameter logic [31:0] BASE        = 32'h1000_0000,
  parameter int unsigned DEPTH       = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        hit,
  output logic        tx,
  output logic        irq
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  tx_state_e        state, state_n;
  logic [DIV_W-1:0] div, div_q, div_q_n, baud_cnt, baud_cnt_n;
  logic [2:0]       bit_cnt, bit_cnt_n;
  logic [7:0]       shreg, shreg_n, fifo_rdata;
  logic [CW-1:0]    fifo_count;
  logic [1:0]       off;
  logic [31:0]      status;
  logic             ie, ovf, wr, bit_done, load, tx_n;
  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic             unused_bits;
`ifdef UART_TX_PARITY_EN
  logic             par_q, par_q_n;
`endif

  assign hit         = (addr[31:4] == BASE[31:4]);
  assign off         = addr[3:2];
  assign wr          = we & hit;
  assign fifo_push   = wr && (off == OFF_TXDATA);
  assign bit_done    = (baud_cnt == div_q - DIV_W'(1));
  assign unused_bits = ^{addr[1:0], wdata[31:17]};

  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (wdata[7:0]),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div <= DEFAULT_DIV;
      ie  <= 1'b0;
      ovf <= 1'b0;
    end else begin
      if (wr) begin
        case (off)
          OFF_STATUS: if (wdata[ST_OVF]) ovf <= 1'b0;
          OFF_CTRL: begin
            div <= (wdata[DIV_W-1:0] == '0) ? DIV_W'(1) : wdata[DIV_W-1:0];
            ie  <= wdata[CTRL_IE_BIT];
          end
          default: ;
        endcase
      end
      if (fifo_push && fifo_full && !fifo_pop) ovf <= 1'b1;
    end
  end

  always_comb begin
    status                         = '0;
    status[ST_FULL]                = fifo_full;
    status[ST_EMPTY]               = fifo_empty;
    status[ST_BUSY]                = (state != IDLE);
    status[ST_OVF]                 = ovf;
    status[ST_COUNT_LSB +: CW]     = fifo_count;
    rdata = '0;
    if (hit) begin
      case (off)
        OFF_STATUS: rdata = status;
        OFF_CTRL: begin
          rdata[DIV_W-1:0]   = div;
          rdata[CTRL_IE_BIT] = ie;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_n    = state;
    div_q_n    = div_q;
    bit_cnt_n  = bit_cnt;
    shreg_n    = shreg;
    load       = 1'b0;
    fifo_pop   = 1'b0;
    baud_cnt_n = bit_done ? '0 : baud_cnt + DIV_W'(1);
`ifdef UART_TX_PARITY_EN
    par_q_n    = par_q;
`endif
    case (state)
      IDLE: begin
        baud_cnt_n = '0;
        load       = ~fifo_empty;
      end
      START: if (bit_done) begin
        state_n   = DATA;
        bit_cnt_n = '0;
      end
      DATA: if (bit_done) begin
        shreg_n   = {1'b0, shreg[7:1]};
        bit_cnt_n = bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
          state_n = PARITY;
`else
          state_n = STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (bit_done) state_n = STOP;
`endif
      STOP: if (bit_done) begin
        state_n = IDLE;
        load    = ~fifo_empty;
      end
      default: state_n = IDLE;
    endcase
    // Loading from IDLE or the end of STOP both start a frame with a fresh divisor.
    if (load) begin
      state_n  = START;
      fifo_pop = 1'b1;
      shreg_n  = fifo_rdata;
      div_q_n  = div;
`ifdef UART_TX_PARITY_EN
      par_q_n  = ^fifo_rdata;
`endif
    end
    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shreg_n[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_n = par_q_n;
`endif
      default: tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      div_q    <= DEFAULT_DIV;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      tx       <= 1'b1;
      irq      <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      div_q    <= div_q_n;
      baud_cnt <= baud_cnt_n;
      bit_cnt  <= bit_cnt_n;
      shreg    <= shreg_n;
      tx       <= tx_n;
      irq      <= ie & fifo_empty & (state == IDLE);
`ifdef UART_TX_PARITY_EN
      par_q    <= par_q_n;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Self-checking bench for uart_tx_mmio: expected tx waveforms are built from frame rules.
module tb_uart_tx_mmio;
  localparam logic [31:0] BASE  = 32'h1000_0000;
  localparam int          DEPTH = 8;
  localparam logic [31:0] A_TX  = BASE;
  localparam logic [31:0] A_ST  = BASE + 32'h4;
  localparam logic [31:0] A_CT  = BASE + 32'h8;

  logic        clk, reset, we, hit, tx, irq;
  logic [31:0] addr, wdata, rdata;

  int checks = 0;
  int errors = 0;

  logic log_q[$];
  logic exp_q[$];
  logic log_on = 1'b0;

  uart_tx_mmio #(.BASE(BASE), .DEPTH(DEPTH), .DEFAULT_DIV(16'd16)) dut (
    .clk(clk), .reset(reset), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .hit(hit), .tx(tx), .irq(irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always begin
    @(posedge clk);
    #2;
    if (log_on) log_q.push_back(tx);
  end

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    we = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    we = 1'b0; addr = 32'h0; wdata = 32'h0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    addr = a;
    #1;
    d = rdata;
  endtask

  task automatic start_log();
    log_q.delete();
    exp_q.delete();
    log_on = 1'b1;
  endtask

  task automatic add_frame(input logic [7:0] b, input int d);
    repeat (d) exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) repeat (d) exp_q.push_back(b[i]);
`ifdef UART_TX_PARITY_EN
    repeat (d) exp_q.push_back(^b);
`endif
    repeat (d) exp_q.push_back(1'b1);
  endtask

  task automatic add_idle(input int n);
    repeat (n) exp_q.push_back(1'b1);
  endtask

  task automatic wait_log();
    for (int i = 0; i < 20000 && log_q.size() < exp_q.size(); i++) @(negedge clk);
    log_on = 1'b0;
  endtask

  function automatic int wave_mismatch();
    for (int i = 0; i < exp_q.size(); i++)
      if (i >= log_q.size() || log_q[i] !== exp_q[i]) return i;
    return -1;
  endfunction

  task automatic test_reset();
    logic [31:0] v;
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b want 1", tx); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b want 0", irq); end
    bus_read(A_ST, v);
    checks++; if (hit !== 1'b1) begin errors++; $display("FAIL reset_hit: got %b want 1", hit); end
    checks++; if (v !== 32'h2) begin errors++; $display("FAIL reset_status: got %h want 00000002", v); end
    bus_read(A_CT, v);
    checks++; if (v !== 32'h10) begin errors++; $display("FAIL reset_ctrl: got %h want 00000010", v); end
  endtask

  task automatic test_single_byte();
    logic [31:0] v;
    logic [7:0]  b;
    int          d, mm;
    for (int k = 0; k < 4; k++) begin
      b = (k == 0) ? 8'h55 : 8'($urandom);
      d = (k == 0) ? 4 : ((k == 1) ? 1 : int'($urandom_range(2, 6)));
      bus_write(A_CT, 32'(d));
      bus_write(A_TX, {24'h0, b});
      start_log();
      add_frame(b, d);
      add_idle(3);
      wait_log();
      mm = wave_mismatch();
      checks++;
      if (mm != -1) begin
        errors++;
        $display("FAIL single_byte_wave: byte %h div %0d sample %0d got %b want %b", b, d, mm, log_q[mm], exp_q[mm]);
      end
      @(negedge clk);
      bus_read(A_ST, v);
      checks++; if (v !== 32'h2) begin errors++; $display("FAIL single_byte_idle_status: got %h want 00000002", v); end
    end
  endtask

  task automatic test_overflow();
    logic [7:0]  data [DEPTH+2];
    logic [31:0] v, want;
    int          mm;
    for (int i = 0; i < DEPTH + 2; i++) data[i] = 8'($urandom);
    bus_write(A_CT, 32'd16);
    @(negedge clk);
    we = 1'b1; addr = A_TX; wdata = {24'h0, data[0]};
    @(negedge clk);
    start_log();
    for (int i = 1; i < DEPTH + 2; i++) begin
      wdata = {24'h0, data[i]};
      @(negedge clk);
    end
    we = 1'b0; addr = 32'h0;
    // The first byte leaves immediately, so DEPTH+1 stores fit and the last one is dropped.
    want = (32'(DEPTH) << 8) | 32'hD;
    bus_read(A_ST, v);
    checks++; if (v !== want) begin errors++; $display("FAIL ovf_status: got %h want %h", v, want); end
    bus_write(A_ST, 32'h8);
    want = (32'(DEPTH) << 8) | 32'h5;
    bus_read(A_ST, v);
    checks++; if (v !== want) begin errors++; $display("FAIL ovf_clear: got %h want %h", v, want); end
    for (int i = 0; i < DEPTH + 1; i++) add_frame(data[i], 16);
    add_idle(4);
    wait_log();
    mm = wave_mismatch();
    checks++;
    if (mm != -1) begin
      errors++;
      $display("FAIL ovf_stream_wave: sample %0d got %b want %b", mm, log_q[mm], exp_q[mm]);
    end
    @(negedge clk);
    bus_read(A_ST, v);
    checks++; if (v !== 32'h2) begin errors++; $display("FAIL ovf_final_status: got %h want 00000002", v); end
  endtask

  task automatic test_div_change();
    logic [7:0]  a, b;
    logic [31:0] v;
    logic [15:0] d;
    int          mm;
    a = 8'($urandom);
    b = 8'($urandom);
    bus_write(A_CT, 32'd4);
    bus_write(A_TX, {24'h0, a});
    start_log();
    add_frame(a, 4);
    add_frame(b, 8);
    add_idle(3);
    repeat (6) @(negedge clk);
    bus_write(A_CT, 32'd8);
    bus_write(A_TX, {24'h0, b});
    wait_log();
    mm = wave_mismatch();
    checks++;
    if (mm != -1) begin
      errors++;
      $display("FAIL div_change_wave: sample %0d got %b want %b", mm, log_q[mm], exp_q[mm]);
    end
    bus_write(A_CT, 32'h0);
    bus_read(A_CT, v);
    checks++; if (v !== 32'h1) begin errors++; $display("FAIL div_zero: got %h want 00000001", v); end
    d = 16'($urandom_range(1, 65535));
    bus_write(A_CT, {$urandom} & 32'hFFFE_0000 | 32'h1_0000 | 32'(d));
    bus_read(A_CT, v);
    checks++; if (v !== {15'h0, 1'b1, d}) begin errors++; $display("FAIL ctrl_readback: got %h want %h", v, {15'h0, 1'b1, d}); end
    bus_write(A_CT, 32'd4);
  endtask

  task automatic test_decode();
    logic [31:0] v, a;
    a = BASE + 32'h20;
    bus_read(a, v);
    checks++; if (hit !== 1'b0) begin errors++; $display("FAIL decode_hit: got %b want 0", hit); end
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL decode_rdata: got %h want 0", v); end
    bus_write(a, 32'h0000_00A5);
    a = {$urandom} | 32'h8000_0000;
    bus_read(a, v);
    checks++; if (hit !== 1'b0 || v !== 32'h0) begin errors++; $display("FAIL decode_rand: hit %b rdata %h want 0/0", hit, v); end
    bus_write(BASE + 32'hC, 32'h0001_0007);
    bus_read(BASE + 32'hC, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL rsvd_read: got %h want 0", v); end
    bus_read(A_TX, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL txdata_read: got %h want 0", v); end
    bus_read(A_ST + 32'h3, v);
    checks++; if (v !== 32'h2) begin errors++; $display("FAIL decode_nopush_status: got %h want 00000002", v); end
    bus_read(A_CT, v);
    checks++; if (v !== 32'h4) begin errors++; $display("FAIL rsvd_write_ignored: got %h want 00000004", v); end
  endtask

  task automatic test_irq();
    bus_write(A_CT, 32'h0001_0004);
    @(negedge clk);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_set: got %b want 1", irq); end
    bus_write(A_TX, 32'($urandom_range(0, 255)));
    repeat (10) @(negedge clk);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_busy: got %b want 0", irq); end
    repeat (35) @(negedge clk);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_after_stop: got %b want 1", irq); end
    bus_write(A_CT, 32'h4);
    @(negedge clk);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_disable: got %b want 0", irq); end
  endtask

  task automatic test_async_reset();
    logic [31:0] v;
    int          mm;
    bus_write(A_CT, 32'h4);
    bus_write(A_TX, 32'h0);
    bus_write(A_TX, 32'($urandom_range(0, 255)));
    bus_write(A_TX, 32'($urandom_range(0, 255)));
    repeat (6) @(negedge clk);
    checks++; if (tx !== 1'b0) begin errors++; $display("FAIL pre_reset_tx: got %b want 0", tx); end
    #2 reset = 1'b1;
    #1;
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL async_reset_tx: got %b want 1", tx); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    bus_read(A_ST, v);
    checks++; if (v !== 32'h2) begin errors++; $display("FAIL post_reset_status: got %h want 00000002", v); end
    bus_read(A_CT, v);
    checks++; if (v !== 32'h10) begin errors++; $display("FAIL post_reset_ctrl: got %h want 00000010", v); end
    start_log();
    add_idle(20);
    wait_log();
    mm = wave_mismatch();
    checks++;
    if (mm != -1) begin
      errors++;
      $display("FAIL post_reset_idle: sample %0d got %b want %b", mm, log_q[mm], exp_q[mm]);
    end
  endtask

  initial begin
    reset = 1'b1; we = 1'b0; addr = 32'h0; wdata = 32'h0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    test_reset();
    test_single_byte();
    test_overflow();
    test_div_change();
    test_decode();
    test_irq();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_mmio.md
# uart_tx_mmio

Memory-mapped UART transmitter. It responds to the RV32I core's data-memory port (MemWriteM / ALUResultM / WriteDataM / ReadDataM) alongside dmem, which makes it a write-target responder on that bus. Bytes the core stores are queued in a small FIFO and serialised LSB-first on `tx` at a programmable baud divisor. The top level muxes `rdata` using `hit`.

## Interface
Parameters:
- `BASE`, 32'h1000_0000: register block base address; bits [3:0] are ignored.
- `DEPTH`, 8: FIFO depth in bytes. Must be a power of 2, ≥2.
- `DEFAULT_DIV`, 16'd16: clocks per bit after reset.

Ports:
- `clk`  in  1  Single clock; everything is rising-edge.
- `reset`  in  1  Asynchronous, active-high reset.
- `we`  in  1  Store strobe (MemWriteM).
- `addr`  in  32  Byte address (ALUResultM).
- `wdata`  in  32  Store data (WriteDataM).
- `rdata`  out  32  Combinational read data. 0 when not `hit`.
- `hit`  out  1  Combinational: `addr[31:4] == BASE[31:4]`.
- `tx`  out  1  Registered serial output. Idle high.
- `irq`  out  1  Registered. Equals `ie & fifo_empty & state==IDLE`.

## Operation
Registers (offset = `addr[3:2]`):
- **0x0 TXDATA**
  - Write pushes `wdata[7:0]`.
  - Reads return 0.
- **0x4 STATUS** (read)
  - bit0 full; bit1 empty; bit2 busy (state≠IDLE); bit3 ovf (sticky).
  - bits[15:8] FIFO count, zero-extended.
  - Writing 1 to bit3 clears ovf. Other bits are read-only.
- **0x8 CTRL**
  - bits[15:0] div; bit16 ie.
  - A written div of 0 is stored as 1.
  - Read returns the stored value.
- **0xC**: reads 0; writes are ignored.

Writes take effect only when `we & hit`, at the clock edge.

FIFO behaviour:
- A push when full is dropped and sets ovf.
- Push and pop in the same cycle are both honoured, including when full: a pop frees the slot in the same cycle.

Transmit FSM (`state`):
- **IDLE**, FIFO not empty: pop into the shift register, latch `div` into `div_q`, go to START.
- **START**: `tx`=0 for `div_q` clocks, then DATA.
- **DATA**: 8 bits LSB-first, `div_q` clocks each. Bit counter runs 0..7.
- **PARITY** (macro only): one bit time, then STOP.
- **STOP**: `tx`=1 for `div_q` clocks. Then:
  - FIFO not empty: pop, latch `div`, go straight to START (back-to-back frames, no idle gap).
  - Otherwise go to IDLE.

Baud counter:
- Counts 0..`div_q`-1 and is reset at each bit boundary.
- A CTRL write mid-frame does not affect the frame in flight.

## Timing
Reset values:
- `tx`=1, `irq`=0, state IDLE, FIFO empty, ovf=0, div=`DEFAULT_DIV`, ie=0.

Latency:
- A TXDATA write at edge N with the FSM in IDLE → pop at edge N+1 → `tx` falls after edge N+1.
- Frame length is 10·div_q clocks (11·div_q with parity).

Reset asserted mid-frame:
- `tx` goes to 1 immediately (asynchronous). The frame is truncated and the FIFO contents are discarded.

Reads:
- `rdata` is combinational from the current register state; same-cycle read-after-write returns the old value.
- STATUS count is `$clog2(DEPTH)+1` bits wide.

## Configuration
Macro `UART_TX_PARITY_EN`:
- **Defined**: the PARITY state is inserted between DATA and STOP. It transmits even parity, i.e. the XOR of the 8 data bits.
- **Undefined**: the PARITY state and its logic are absent; DATA goes directly to STOP.

## Structure
Package `uart_tx_pkg` holds:
- the `tx_state_e` enum (IDLE, START, DATA, PARITY, STOP);
- register offset constants;
- STATUS bit-position constants;
- the CTRL field widths.

Sub-module `sync_fifo` (parameters WIDTH, DEPTH):
- push/pop, full/empty/count;
- pointers one bit wider than the index, to tell full from empty on wrap-around.

## Test plan
- **Single byte.** Reset, div=4, store 0x55 to BASE+0.
  - `tx` low at cycle 1–4, then 1,0,1,0,1,0,1,0 in 4-clock bits, then high for 4 clocks.
  - 40 clocks total, then busy=0.
  - With the macro: a 0 parity bit is inserted, 44 clocks total.
- **FIFO fill and overflow.** div=16, store DEPTH+2 bytes back-to-back.
  - One byte is popped immediately, so exactly 1 store is dropped.
  - STATUS reads full=1, ovf=1.
  - Write 0x8 to STATUS → ovf=0.
  - All DEPTH+1 accepted bytes then appear in order with no idle gap between frames.
- **Divisor change mid-frame.** Write div=8 during a div=4 frame.
  - The current frame keeps 4-clock bits.
  - The next frame uses 8-clock bits.
  - Writing div=0 reads back 1.
- **Address decode.** Store to BASE+0x20.
  - No push; `hit`=0; `rdata`=0.
  - A load from BASE+4 after reset returns 0x0000_0002 (empty=1).
- **irq.** Set ie=1 with the FIFO empty → `irq`=1 after the next edge.
  - Store a byte → `irq`=0 during the frame, back to 1 after STOP.
- **Async reset mid-frame.** Assert `reset` during DATA.
  - `tx`=1 with no clock edge.
  - After release: count=0, state IDLE, div=`DEFAULT_DIV`.
